// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants and hex glyph table (active-low, bit6=a .. bit0=g).
package seg_pkg;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational nibble to active-low seven-segment glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex_to_seg(nibble_i);
endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed hex display scanner with per-frame input shadowing, blanking,
// decimal points, leading-zero suppression and an all-off gap at the start of each slot.
module seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzs_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);
  localparam int CW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0]             cnt_q;
  logic [IW-1:0]             idx_q;
  logic [4*NUM_DIGITS-1:0]   sh_data_q;
  logic [NUM_DIGITS-1:0]     sh_dp_q, sh_en_q, lz;
  logic                      sh_lzs_q, z;
  logic [6:0]                seg_q, hex_seg;
  logic                      dp_q, tick_q;
  logic [NUM_DIGITS-1:0]     an_q, an_act;
  logic [3:0]                nib;
  logic                      wrap, last, cap, gap, blank;
  assign wrap   = cnt_q == CW'(DIV - 1);
  assign last   = idx_q == IW'(NUM_DIGITS - 1);
  assign cap    = cnt_q == '0 && idx_q == '0;
  assign gap    = cnt_q < CW'(BLANK_CYCLES);
  assign nib    = sh_data_q[{idx_q, 2'b00} +: 4];
  assign an_act = ~(NUM_DIGITS'(1) << idx_q);
  // lz[i] is set when every shadow nibble from the top digit down to i is zero
  always_comb begin
    z  = 1'b1;
    lz = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z     = z & (sh_data_q[4*i +: 4] == 4'd0);
      lz[i] = z;
    end
  end
  assign blank = !sh_en_q[idx_q] || (sh_lzs_q && idx_q != '0 && lz[idx_q]);
  seg_hex_decode u_dec (
    .nibble_i (nib),
    .seg_o    (hex_seg)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      sh_lzs_q  <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
      an_q      <= '1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      if (wrap) idx_q <= last ? '0 : idx_q + 1'b1;
      if (cap) begin
        sh_data_q <= data;
        sh_dp_q   <= dp_in;
        sh_en_q   <= digit_en;
        sh_lzs_q  <= lzs_en;
      end
      tick_q <= cap;
      an_q   <= gap ? '1 : an_act;
      seg_q  <= (gap || blank) ? SEG_OFF : hex_seg;
      dp_q   <= (gap || blank) ? 1'b1 : ~sh_dp_q[idx_q];
    end
  end
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: frame-by-frame directed vectors for seg_scan (4 digits, DIV=8, 2 blank cycles).
module tb_seg_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0, digit_en = '0;
  logic        lzs_en = 1'b0;
  logic [6:0]  seg;
  logic        dp, frame_tick;
  logic [3:0]  an;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [15:0]     data, mid;
    logic            tear;
    logic [3:0]      dpi, en;
    logic            lzs;
    logic [3:0][6:0] segs;
    logic [3:0]      dpo;
  } vec_t;

  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  vec_t vecs[$];

  seg_scan #(.NUM_DIGITS(4), .DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lzs_en     (lzs_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [15:0] d, logic [3:0] dpi, logic [3:0] en, logic lzs,
                              logic tear, logic [15:0] mid, logic [3:0][6:0] segs, logic [3:0] dpo);
    vec_t v;
    v.data = d; v.dpi = dpi; v.en = en; v.lzs = lzs; v.tear = tear; v.mid = mid;
    v.segs = segs; v.dpo = dpo;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge before a capture; checks every cycle of one 32-cycle frame.
  task automatic check_frame(vec_t v);
    int p, d;
    data = v.data; dp_in = v.dpi; digit_en = v.en; lzs_en = v.lzs;
    for (int k = 1; k <= 32; k++) begin
      if (v.tear && k == 12) data = v.mid;
      step();
      p = (k - 1) % 8;
      d = (k - 1) / 8;
      chk("frame_tick", {7'd0, frame_tick}, {7'd0, k == 1});
      if (p < 2) begin
        chk("gap_an", {4'd0, an}, 8'h0F);
        chk("gap_seg", {1'b0, seg}, {1'b0, OFF});
        chk("gap_dp", {7'd0, dp}, 8'd1);
      end else begin
        chk("an", {4'd0, an}, {4'd0, ~(4'b0001 << d)});
        chk("seg", {1'b0, seg}, {1'b0, v.segs[d]});
        chk("dp", {7'd0, dp}, {7'd0, v.dpo[d]});
      end
    end
  endtask

  initial begin
    vecs.push_back(mk(16'h1234, 4'h0, 4'hF, 1'b0, 1'b0, 16'h0,
                      {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF));
    for (int h = 0; h < 16; h++)
      vecs.push_back(mk(16'(h), 4'h0, 4'hF, 1'b0, 1'b0, 16'h0,
                        {7'b0000001, 7'b0000001, 7'b0000001, HEX[h]}, 4'hF));
    vecs.push_back(mk(16'h0040, 4'h0, 4'hF, 1'b1, 1'b0, 16'h0,
                      {OFF, OFF, 7'b1001100, 7'b0000001}, 4'hF));
    vecs.push_back(mk(16'h0000, 4'h0, 4'hF, 1'b1, 1'b0, 16'h0,
                      {OFF, OFF, OFF, 7'b0000001}, 4'hF));
    vecs.push_back(mk(16'h5678, 4'h0, 4'hF, 1'b0, 1'b1, 16'hABCD,
                      {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}, 4'hF));
    vecs.push_back(mk(16'hABCD, 4'h0, 4'hF, 1'b0, 1'b0, 16'h0,
                      {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}, 4'hF));
    vecs.push_back(mk(16'hABCD, 4'b0100, 4'b1110, 1'b0, 1'b0, 16'h0,
                      {7'b0001000, 7'b1100000, 7'b0110001, OFF}, 4'b1011));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {4'd0, an}, 8'h0F);
    chk("rst_seg", {1'b0, seg}, {1'b0, OFF});
    chk("rst_dp", {7'd0, dp}, 8'd1);
    chk("rst_tick", {7'd0, frame_tick}, 8'd0);
    rst = 1'b0;
    foreach (vecs[i]) check_frame(vecs[i]);
    // Run into digit 2 of the next frame, then reset with idx=2, cnt=5.
    repeat (21) step();
    chk("pre_rst_an", {4'd0, an}, 8'h0B);
    rst = 1'b1;
    step();
    chk("mid_rst_an", {4'd0, an}, 8'h0F);
    chk("mid_rst_seg", {1'b0, seg}, {1'b0, OFF});
    chk("mid_rst_dp", {7'd0, dp}, 8'd1);
    rst = 1'b0;
    check_frame(vecs[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
